// File: rtl/delay_load_seq_if.sv
// rtl/delay_load_seq_if.sv - command handshake and delay-bank strobe bundle for delay_load_seq
interface delay_load_seq_if #(
    parameter int NUM_LANES = 10,
    parameter int LANE_BITS = 4
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [LANE_BITS-1:0] cmd_lane;
    logic [4:0]           cmd_delay;
    logic [4:0]           dly_delay;
    logic [NUM_LANES-1:0] dly_ld;
    logic                 dly_set;

    modport master (
        output cmd_valid, cmd_op, cmd_lane, cmd_delay,
        input  cmd_ready, dly_delay, dly_ld, dly_set
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_lane, cmd_delay,
        output cmd_ready, dly_delay, dly_ld, dly_set
    );
endinterface

// File: rtl/delay_load_seq.sv
// rtl/delay_load_seq.sv - serialises tap writes into a pipelined delay bank with ld/set spacing and shadow readback
module delay_load_seq #(
    parameter int         NUM_LANES     = 10,
    parameter int         LANE_BITS     = 4,
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [4:0] DELAY_INIT    = 5'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    delay_load_seq_if.slave      bus,
    output logic                 pending,
    output logic                 cmd_err,
    input  logic [LANE_BITS-1:0] rd_lane,
    output logic [4:0]           rd_delay
);
    typedef enum logic [1:0] {IDLE, STROBE, SETTLE} state_t;

    localparam logic [1:0] OP_WRITE     = 2'd1;
    localparam logic [1:0] OP_WRITE_ALL = 2'd2;
    localparam logic [1:0] OP_APPLY     = 2'd3;
    localparam logic [2:0] CNT_LOAD     = (SETTLE_CYCLES > 0) ? 3'(SETTLE_CYCLES - 1) : 3'd0;

    state_t               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic [4:0]           delay_q, delay_d;
    logic [NUM_LANES-1:0] ld_q, ld_d;
    logic                 set_q, set_d;
    logic                 pend_q, pend_d;
    logic                 err_q, err_d;
    logic [4:0]           shadow_q [NUM_LANES];
    logic [4:0]           shadow_d [NUM_LANES];
    logic                 accept;
    logic                 lane_ok;

    assign accept  = bus.cmd_valid & ready_q;
    assign lane_ok = int'(bus.cmd_lane) < NUM_LANES;

    // Strobes and shadow updates are decided at the accepting edge so they
    // appear, registered, in the STROBE cycle itself.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        delay_d  = delay_q;
        ld_d     = '0;
        set_d    = 1'b0;
        pend_d   = pend_q;
        err_d    = err_q;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        OP_WRITE: begin
                            if (lane_ok) begin
                                state_d = STROBE;
                                delay_d = bus.cmd_delay;
                                pend_d  = 1'b1;
                                for (int i = 0; i < NUM_LANES; i++) begin
                                    if (int'(bus.cmd_lane) == i) begin
                                        ld_d[i]     = 1'b1;
                                        shadow_d[i] = bus.cmd_delay;
                                    end
                                end
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_WRITE_ALL: begin
                            state_d = STROBE;
                            delay_d = bus.cmd_delay;
                            pend_d  = 1'b1;
                            ld_d    = '1;
                            for (int i = 0; i < NUM_LANES; i++) begin
                                shadow_d[i] = bus.cmd_delay;
                            end
                        end
                        OP_APPLY: begin
                            state_d = STROBE;
                            set_d   = 1'b1;
                            pend_d  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            STROBE: begin
                if (SETTLE_CYCLES > 0) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            ready_q <= 1'b0;
            delay_q <= 5'd0;
            ld_q    <= '0;
            set_q   <= 1'b0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                shadow_q[i] <= DELAY_INIT;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            delay_q  <= delay_d;
            ld_q     <= ld_d;
            set_q    <= set_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        rd_delay = 5'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (int'(rd_lane) == i) begin
                rd_delay = shadow_q[i];
            end
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.dly_delay = delay_q;
    assign bus.dly_ld    = ld_q;
    assign bus.dly_set   = set_q;
    assign pending       = pend_q;
    assign cmd_err       = err_q;
endmodule

// File: tb/tb_delay_load_seq.sv
// tb/tb_delay_load_seq.sv - directed self-checking bench for delay_load_seq (SETTLE_CYCLES=2 and =0 instances)
module tb_delay_load_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] rd_lane_a, rd_lane_b;
    logic [4:0] rd_delay_a, rd_delay_b;
    logic       pending_a, pending_b, cmd_err_a, cmd_err_b;
    int         checks = 0;
    int         errors = 0;
    int         cnt;
    int         pulses;
    logic       prev_ld;

    always #5 clk = ~clk;

    delay_load_seq_if #(.NUM_LANES(10), .LANE_BITS(4)) bus_a ();
    delay_load_seq_if #(.NUM_LANES(10), .LANE_BITS(4)) bus_b ();

    delay_load_seq #(.NUM_LANES(10), .LANE_BITS(4), .SETTLE_CYCLES(2), .DELAY_INIT(5'd0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .pending(pending_a),
        .cmd_err(cmd_err_a), .rd_lane(rd_lane_a), .rd_delay(rd_delay_a)
    );

    delay_load_seq #(.NUM_LANES(10), .LANE_BITS(4), .SETTLE_CYCLES(0), .DELAY_INIT(5'd7)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .pending(pending_b),
        .cmd_err(cmd_err_b), .rd_lane(rd_lane_b), .rd_delay(rd_delay_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready_a();
        for (int i = 0; i < 20 && !bus_a.cmd_ready; i++) step();
        check("wait_ready_a", 32'(bus_a.cmd_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        bus_a.cmd_valid = 1'b0; bus_a.cmd_op = 2'd0; bus_a.cmd_lane = 4'd0; bus_a.cmd_delay = 5'd0;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_op = 2'd0; bus_b.cmd_lane = 4'd0; bus_b.cmd_delay = 5'd0;
        rd_lane_a = 4'd0; rd_lane_b = 4'd0;
        step(); step();
        check("ready_in_reset", 32'(bus_a.cmd_ready), 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_ready", 32'(bus_a.cmd_ready), 32'd1);
        check("rst_delay", 32'(bus_a.dly_delay), 32'd0);
        check("rst_ld", 32'(bus_a.dly_ld), 32'd0);
        check("rst_set", 32'(bus_a.dly_set), 32'd0);
        check("rst_pending", 32'(pending_a), 32'd0);
        check("rst_err", 32'(cmd_err_a), 32'd0);
        check("rst_ready_b", 32'(bus_b.cmd_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            rd_lane_a = 4'(i); rd_lane_b = 4'(i);
            #1;
            check($sformatf("rst_shadow_a%0d", i), 32'(rd_delay_a), 32'd0);
            check($sformatf("rst_shadow_b%0d", i), 32'(rd_delay_b), 32'd7);
        end
        rd_lane_b = 4'd12;
        #1;
        check("rd_out_of_range", 32'(rd_delay_b), 32'd0);

        // WRITE lane 3 = 17
        bus_a.cmd_valid = 1'b1; bus_a.cmd_op = 2'd1; bus_a.cmd_lane = 4'd3; bus_a.cmd_delay = 5'd17;
        step();
        bus_a.cmd_valid = 1'b0;
        check("wr_ld", 32'(bus_a.dly_ld), 32'h008);
        check("wr_delay", 32'(bus_a.dly_delay), 32'd17);
        check("wr_pending", 32'(pending_a), 32'd1);
        check("wr_ready_t1", 32'(bus_a.cmd_ready), 32'd0);
        check("wr_set", 32'(bus_a.dly_set), 32'd0);
        step();
        check("wr_ld_t2", 32'(bus_a.dly_ld), 32'd0);
        check("wr_delay_hold", 32'(bus_a.dly_delay), 32'd17);
        check("wr_ready_t2", 32'(bus_a.cmd_ready), 32'd0);
        step();
        check("wr_ready_t3", 32'(bus_a.cmd_ready), 32'd0);
        step();
        check("wr_ready_t4", 32'(bus_a.cmd_ready), 32'd1);
        rd_lane_a = 4'd3; #1;
        check("wr_shadow3", 32'(rd_delay_a), 32'd17);
        rd_lane_a = 4'd2; #1;
        check("wr_shadow2", 32'(rd_delay_a), 32'd0);

        // WRITE_ALL 9, then APPLY held valid
        bus_a.cmd_valid = 1'b1; bus_a.cmd_op = 2'd2; bus_a.cmd_delay = 5'd9;
        step();
        check("wa_ld", 32'(bus_a.dly_ld), 32'h3FF);
        check("wa_delay", 32'(bus_a.dly_delay), 32'd9);
        check("wa_pending", 32'(pending_a), 32'd1);
        bus_a.cmd_op = 2'd3; bus_a.cmd_delay = 5'd30;
        cnt = 0;
        for (int i = 0; i < 20 && !bus_a.dly_set; i++) begin
            step();
            cnt++;
            check($sformatf("wa_no_ld_%0d", cnt), 32'(bus_a.dly_ld), 32'd0);
        end
        bus_a.cmd_valid = 1'b0;
        check("apply_seen", 32'(bus_a.dly_set), 32'd1);
        check("ld_to_set_cycles", 32'(cnt), 32'd4);
        check("apply_pending", 32'(pending_a), 32'd0);
        check("apply_delay", 32'(bus_a.dly_delay), 32'd9);
        step();
        check("apply_set_single", 32'(bus_a.dly_set), 32'd0);
        for (int i = 0; i < 10; i++) begin
            rd_lane_a = 4'(i); #1;
            check($sformatf("wa_shadow%0d", i), 32'(rd_delay_a), 32'd9);
        end

        // WRITE to out-of-range lane 12
        wait_ready_a();
        bus_a.cmd_valid = 1'b1; bus_a.cmd_op = 2'd1; bus_a.cmd_lane = 4'd12; bus_a.cmd_delay = 5'd5;
        step();
        bus_a.cmd_valid = 1'b0;
        check("bad_ld", 32'(bus_a.dly_ld), 32'd0);
        check("bad_err", 32'(cmd_err_a), 32'd1);
        check("bad_ready", 32'(bus_a.cmd_ready), 32'd1);
        check("bad_delay", 32'(bus_a.dly_delay), 32'd9);
        bus_a.cmd_valid = 1'b1; bus_a.cmd_op = 2'd0;
        step();
        bus_a.cmd_valid = 1'b0;
        check("nop_ld", 32'(bus_a.dly_ld), 32'd0);
        check("nop_set", 32'(bus_a.dly_set), 32'd0);
        check("nop_ready", 32'(bus_a.cmd_ready), 32'd1);
        check("err_sticky", 32'(cmd_err_a), 32'd1);
        rd_lane_a = 4'd4; #1;
        check("bad_shadow4", 32'(rd_delay_a), 32'd9);

        // SETTLE_CYCLES=0: back-to-back WRITEs held valid
        bus_b.cmd_valid = 1'b1; bus_b.cmd_op = 2'd1; bus_b.cmd_lane = 4'd1; bus_b.cmd_delay = 5'd3;
        pulses = 0; prev_ld = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("b2b_ld_%0d", k), 32'(bus_b.dly_ld), (k % 2 == 1) ? 32'h002 : 32'd0);
            check($sformatf("b2b_ready_%0d", k), 32'(bus_b.cmd_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (bus_b.dly_ld != '0) begin
                pulses++;
                check($sformatf("b2b_adjacent_%0d", k), 32'(prev_ld), 32'd0);
            end
            prev_ld = (bus_b.dly_ld != '0);
        end
        bus_b.cmd_valid = 1'b0;
        check("b2b_pulses", 32'(pulses), 32'd4);
        rd_lane_b = 4'd1; #1;
        check("b2b_shadow1", 32'(rd_delay_b), 32'd3);
        rd_lane_b = 4'd0; #1;
        check("b2b_shadow0", 32'(rd_delay_b), 32'd7);

        // Reset during SETTLE after a WRITE, with an APPLY waiting
        wait_ready_a();
        bus_a.cmd_valid = 1'b1; bus_a.cmd_op = 2'd1; bus_a.cmd_lane = 4'd5; bus_a.cmd_delay = 5'd21;
        step();
        bus_a.cmd_op = 2'd3;
        check("rs_ld", 32'(bus_a.dly_ld), 32'h020);
        step();
        rst_n = 1'b0;
        step();
        check("rs_pending", 32'(pending_a), 32'd0);
        check("rs_delay", 32'(bus_a.dly_delay), 32'd0);
        check("rs_set", 32'(bus_a.dly_set), 32'd0);
        check("rs_err", 32'(cmd_err_a), 32'd0);
        check("rs_ready", 32'(bus_a.cmd_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            rd_lane_a = 4'(i); #1;
            check($sformatf("rs_shadow%0d", i), 32'(rd_delay_a), 32'd0);
        end
        rd_lane_b = 4'd1; #1;
        check("rs_shadow_b1", 32'(rd_delay_b), 32'd7);
        bus_a.cmd_valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("rs_no_set_%0d", k), 32'(bus_a.dly_set), 32'd0);
        end
        check("rs_ready_after", 32'(bus_a.cmd_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
